// File: rtl/kbuf_ctrl_pkg.sv
// Shared constants and FSM encodings for the keyboard controller that sequences
// the KBUF SFR.
package kbuf_ctrl_pkg;

  localparam int SFR_OP_LEN = 4;
  localparam logic [SFR_OP_LEN-1:0] OP_KBUF_WR_BYTE = 4'h6;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_WRITE    = 2'd1,
    W_WAIT_ACK = 2'd2
  } wr_state_t;

endpackage

// File: rtl/kbuf_ctrl_ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// frame FSM with inter-edge timeout. Emits a validated byte or a parity error.
module kbuf_ctrl_ps2_rx_frame
  import kbuf_ctrl_pkg::*;
#(
  parameter int FILTER_CYC  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_parity_err
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_reg;
  logic          filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic [TW-1:0] tmo_cnt_reg;

  rx_state_t     state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;

  logic          strobe;
  logic          sdata;
  logic          timeout;

  assign strobe  = filt_prev_reg & ~filt_reg;
  assign sdata   = data_sync_reg[1];
  assign timeout = (tmo_cnt_reg == TW'(TIMEOUT_CYC));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_reg  <= '0;
      data_sync_reg <= '0;
      filt_reg      <= 1'b0;
      filt_prev_reg <= 1'b0;
      filt_cnt_reg  <= '0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], i_ps2_clk};
      data_sync_reg <= {data_sync_reg[0], i_ps2_data};
      filt_prev_reg <= filt_reg;
      // Any sample matching the current level restarts the run of differing samples.
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_CYC - 1)) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (strobe || state_reg == RX_IDLE) begin
      tmo_cnt_reg <= '0;
    end else if (!timeout) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= RX_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    o_byte_valid = 1'b0;
    o_parity_err = 1'b0;
    if (state_reg != RX_IDLE && timeout) begin
      state_next = RX_IDLE;
    end else if (strobe) begin
      case (state_reg)
        RX_IDLE: begin
          if (!sdata) begin
            state_next   = RX_DATA;
            bit_cnt_next = '0;
          end
        end
        RX_DATA: begin
          shift_next   = {sdata, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
        end
        RX_PARITY: begin
          parity_next = sdata;
          state_next  = RX_STOP;
        end
        RX_STOP: begin
          if (sdata && (^{shift_reg, parity_reg})) o_byte_valid = 1'b1;
          else                                     o_parity_err = 1'b1;
          state_next = RX_IDLE;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  assign o_byte = shift_reg;

endmodule

// File: rtl/kbuf_ctrl.sv
// Keyboard controller: receives PS/2 scancodes, filters break sequences, queues
// them and feeds KBUF one byte per CPU acknowledge with a level interrupt.
module kbuf_ctrl
  import kbuf_ctrl_pkg::*;
#(
  parameter int FILTER_CYC  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_BREAK  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ps2_clk,
  input  logic                  i_ps2_data,
  input  logic                  i_ack,
  output logic [SFR_OP_LEN-1:0] o_op,
  output logic [7:0]            o_byte,
  output logic                  o_irq,
  output logic                  o_parity_err,
  output logic                  o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       rx_valid;
  logic [7:0] rx_byte;

  kbuf_ctrl_ps2_rx_frame #(
    .FILTER_CYC  (FILTER_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_byte_valid (rx_valid),
    .o_byte       (rx_byte),
    .o_parity_err (o_parity_err)
  );

  logic          break_pending_reg;
  logic          pass;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [7:0]    mem_reg [FIFO_DEPTH];
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [7:0]    byte_reg;
  wr_state_t     w_state_reg, w_state_next;

  // Break code and its follower are dropped; an extended prefix always passes.
  always_comb begin
    pass = 1'b1;
    if (DROP_BREAK != 0) begin
      if (rx_byte == PS2_BREAK)      pass = 1'b0;
      else if (rx_byte == PS2_EXT)   pass = 1'b1;
      else if (break_pending_reg)    pass = 1'b0;
    end
  end

  assign push  = rx_valid & pass;
  assign pop   = (w_state_reg == W_WRITE);
  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      break_pending_reg <= 1'b0;
    end else if (rx_valid && DROP_BREAK != 0) begin
      if (rx_byte == PS2_BREAK)                           break_pending_reg <= 1'b1;
      else if (rx_byte != PS2_EXT && break_pending_reg)   break_pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_reg[tail_reg] <= rx_byte;
        tail_reg          <= tail_reg + 1'b1;
      end
      if (pop) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CW'(wr_en) - CW'(pop);
      if (push && !wr_en) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:     if (count_reg != '0) w_state_next = W_WRITE;
      W_WRITE:    w_state_next = W_WAIT_ACK;
      W_WAIT_ACK: if (i_ack) w_state_next = W_IDLE;
      default:    w_state_next = W_IDLE;
    endcase
  end

  // The head is captured on entry to W_WRITE so o_byte holds it afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state_reg <= W_IDLE;
      byte_reg    <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (w_state_reg == W_IDLE && w_state_next == W_WRITE) byte_reg <= mem_reg[head_reg];
    end
  end

  assign o_op       = (w_state_reg == W_WRITE) ? OP_KBUF_WR_BYTE : '0;
  assign o_byte     = byte_reg;
  assign o_irq      = (w_state_reg == W_WAIT_ACK);
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_kbuf_ctrl.sv
// Self-checking bench for kbuf_ctrl: directed scenarios plus random frames and
// acks, compared against a queue-based model of the scancode path.
module tb_kbuf_ctrl;
  import kbuf_ctrl_pkg::*;

  localparam int FILTER = 8;
  localparam int TMO    = 400;
  localparam int DEPTH  = 4;
  localparam int HP     = 20;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ps2_clk = 1'b1;
  logic                  ps2_data = 1'b1;
  logic                  ack = 1'b0;
  logic [SFR_OP_LEN-1:0] o_op;
  logic [7:0]            o_byte;
  logic                  o_irq;
  logic                  o_parity_err;
  logic                  o_overflow;

  kbuf_ctrl #(
    .FILTER_CYC  (FILTER),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (DEPTH),
    .DROP_BREAK  (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .i_ack        (ack),
    .o_op         (o_op),
    .o_byte       (o_byte),
    .o_irq        (o_irq),
    .o_parity_err (o_parity_err),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int        cyc = 0;
  int        valid_cyc = 0;
  int        last_lat = -1;
  int        perr_cnt = 0;
  int        op_bad = 0;
  logic [SFR_OP_LEN-1:0] prev_op = '0;
  logic [7:0] obs_w[$];

  // Model state
  logic [7:0] mq[$];
  logic [7:0] exp_w[$];
  bit         in_flight = 0;
  bit         ovf = 0;
  bit         brk = 0;
  int         exp_perr = 0;
  logic [7:0] last_w = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.rx_valid) valid_cyc = cyc;
      if (o_parity_err) perr_cnt++;
      if (o_op !== '0) begin
        if (o_op !== OP_KBUF_WR_BYTE || prev_op !== '0) op_bad++;
        obs_w.push_back(o_byte);
        last_lat = cyc - valid_cyc;
      end
      prev_op = o_op;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic service();
    if (!in_flight && mq.size() > 0) begin
      last_w = mq.pop_front();
      exp_w.push_back(last_w);
      in_flight = 1;
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (b == 8'hF0) begin
      brk = 1;
      return;
    end
    if (b != 8'hE0 && brk) begin
      brk = 0;
      return;
    end
    if (mq.size() == DEPTH) ovf = 1;
    else mq.push_back(b);
    service();
  endtask

  task automatic check_all(input string tag);
    int n;
    chk($sformatf("%s write_count", tag), 32'(obs_w.size()), 32'(exp_w.size()));
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s write_byte[%0d]", tag, i), 32'(obs_w[i]), 32'(exp_w[i]));
    obs_w.delete();
    exp_w.delete();
    chk($sformatf("%s irq", tag), 32'(o_irq), 32'(in_flight));
    chk($sformatf("%s overflow", tag), 32'(o_overflow), 32'(ovf));
    chk($sformatf("%s parity_err_pulses", tag), 32'(perr_cnt), 32'(exp_perr));
    chk($sformatf("%s op_pulse_shape", tag), 32'(op_bad), 32'd0);
    chk($sformatf("%s byte_hold", tag), 32'(o_byte), 32'(last_w));
    $display("txn %-16s irq=%0b byte=%02h ovf=%0b perr=%0d", tag, o_irq, o_byte, o_overflow, perr_cnt);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HP) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    logic par;
    logic stp;
    par = ~(^b) ^ bad_par;
    stp = ~bad_stop;
    send_bits({stp, par, b, 1'b0}, 11);
    if (bad_par || bad_stop) exp_perr++;
    else model_accept(b);
    repeat (10) @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk($sformatf("%s irq_after_ack", tag), 32'(o_irq), 32'd0);
    in_flight = 0;
    service();
    repeat (10) @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s op", tag), 32'(o_op), 32'd0);
    chk($sformatf("%s byte", tag), 32'(o_byte), 32'd0);
    chk($sformatf("%s irq", tag), 32'(o_irq), 32'd0);
    chk($sformatf("%s parity_err", tag), 32'(o_parity_err), 32'd0);
    chk($sformatf("%s overflow", tag), 32'(o_overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_zero("post_reset");

    // Single good frame with latency check
    send_frame(8'h1C, 0, 0, "frame_1C");
    chk("latency_1C", 32'(last_lat), 32'd2);
    do_ack("ack_1C");

    // Break filtering
    send_frame(8'hF0, 0, 0, "brk_F0");
    send_frame(8'h1C, 0, 0, "brk_1C");
    send_frame(8'hE0, 0, 0, "ext_E0");
    send_frame(8'h74, 0, 0, "ext_74");
    do_ack("ack_E0");
    do_ack("ack_74");

    // Framing errors
    send_frame(8'h1C, 1, 0, "bad_parity");
    send_frame(8'h1C, 0, 1, "bad_stop");

    // Overflow
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 0, 0, $sformatf("ovf_%02h", i));
    for (int i = 0; i < 5; i++) do_ack($sformatf("ovf_ack%0d", i));

    // Partial frame abandoned by timeout
    send_bits(11'b000_0000_1010, 4);
    repeat (TMO + 50) @(negedge clk);
    check_all("timeout");
    send_frame(8'h29, 0, 0, "after_tmo_29");
    do_ack("ack_29");

    // Random frames and acks
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      rb = 8'($urandom);
      if ($urandom_range(0, 4) == 0) rb = 8'hF0;
      else if ($urandom_range(0, 9) == 0) rb = 8'hE0;
      if (r <= 5)      send_frame(rb, 0, 0, $sformatf("rnd%0d_%02h", t, rb));
      else if (r == 6) send_frame(rb, 1, 0, $sformatf("rnd%0d_par", t));
      else if (r == 7) send_frame(rb, 0, 1, $sformatf("rnd%0d_stop", t));
      else             do_ack($sformatf("rnd%0d_ack", t));
    end

    // Async reset mid-frame while waiting for ack, with overflow sticky
    if (in_flight) do_ack("pre_rst_ack");
    send_frame(8'h44, 0, 0, "pre_rst_44");
    ovf = 1;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'(8'h50 + i), 0, 0, $sformatf("pre_rst_fill%0d", i));
    send_bits(11'b000_0000_0010, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    mq.delete();
    exp_w.delete();
    obs_w.delete();
    in_flight = 0;
    ovf = 0;
    brk = 0;
    last_w = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_zero("in_rst");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h5A, 0, 0, "after_rst_5A");
    do_ack("ack_5A");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
